// File: rtl/rv_pkg.sv
// Shared writeback/scoreboard types: register index, writeback request, arbiter pointer.
// Used by reg_wb_arbiter and rr_arb2.
package rv_pkg;

  localparam int RV_XLEN   = 32;
  localparam int RV_NREG   = 32;
  localparam int REG_IDX_W = $clog2(RV_NREG);

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  typedef struct packed {
    logic                valid;
    reg_idx_t            rd;
    logic [RV_XLEN-1:0]  data;
  } wb_req_t;

  typedef enum logic {
    RR_A = 1'b0,
    RR_B = 1'b1
  } rr_ptr_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; the priority pointer only moves when both
// requesters compete, so an uncontested winner does not lose its next turn.
module rr_arb2
  import rv_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_a_i,
  input  logic req_b_i,
  output logic gnt_a_o,
  output logic gnt_b_o
);

  rr_ptr_e ptr_q, ptr_d;
  logic    contested;

  assign contested = !rst_i && req_a_i && req_b_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= RR_A;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (contested) begin
      ptr_d = (ptr_q == RR_A) ? RR_B : RR_A;
    end
  end

  always_comb begin
    gnt_a_o = 1'b0;
    gnt_b_o = 1'b0;
    if (!rst_i) begin
      if (req_a_i && (!req_b_i || ptr_q == RR_A)) begin
        gnt_a_o = 1'b1;
      end else if (req_b_i) begin
        gnt_b_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Writeback arbiter with pending-register scoreboard and registered register-file write port.
// Define WB_BYPASS_EN to forward the in-progress write to issuing sources instead of stalling.
module reg_wb_arbiter
  import rv_pkg::*;
#(
  parameter int XLEN = RV_XLEN,
  parameter int NREG = RV_NREG
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            a_valid,
  input  reg_idx_t        a_rd,
  input  logic [XLEN-1:0] a_data,
  output logic            a_ready,
  input  logic            b_valid,
  input  reg_idx_t        b_rd,
  input  logic [XLEN-1:0] b_data,
  output logic            b_ready,
  input  logic            issue_valid,
  input  reg_idx_t        issue_rd,
  input  reg_idx_t        issue_rs1,
  input  reg_idx_t        issue_rs2,
  output logic            issue_stall,
  output logic            reg_write,
  output reg_idx_t        wr_rd,
  output logic [XLEN-1:0] wr_data
`ifdef WB_BYPASS_EN
  ,
  output logic            fwd_rs1,
  output logic            fwd_rs2,
  output logic [XLEN-1:0] fwd_data
`endif
);

  wb_req_t         a_req, b_req, win;
  logic            reg_write_q;
  reg_idx_t        wr_rd_q;
  logic [XLEN-1:0] wr_data_q;
  logic [NREG-1:0] pending_q, pending_d, set_vec, clr_vec;
  logic            issue_acc;
  logic            byp_rs1, byp_rs2;
  logic            haz_rs1, haz_rs2, haz_rd;

  assign a_req = '{valid: a_valid, rd: a_rd, data: a_data};
  assign b_req = '{valid: b_valid, rd: b_rd, data: b_data};

  rr_arb2 u_arb (
    .clk_i   (clk),
    .rst_i   (rst),
    .req_a_i (a_valid),
    .req_b_i (b_valid),
    .gnt_a_o (a_ready),
    .gnt_b_o (b_ready)
  );

  always_comb begin
    win = '0;
    if (a_ready) begin
      win = a_req;
    end else if (b_ready) begin
      win = b_req;
    end
  end

  // Output register: winner of cycle N drives the register file in cycle N+1.
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write_q <= 1'b0;
      wr_rd_q     <= '0;
      wr_data_q   <= '0;
    end else begin
      reg_write_q <= win.valid && (win.rd != '0);
      if (win.valid) begin
        wr_rd_q   <= win.rd;
        wr_data_q <= win.data;
      end
    end
  end

  // A write still sitting in the output register when reset asserts is dropped.
  assign reg_write = reg_write_q && !rst;
  assign wr_rd     = wr_rd_q;
  assign wr_data   = wr_data_q;

`ifdef WB_BYPASS_EN
  assign byp_rs1  = reg_write && (wr_rd_q == issue_rs1);
  assign byp_rs2  = reg_write && (wr_rd_q == issue_rs2);
  assign fwd_rs1  = byp_rs1;
  assign fwd_rs2  = byp_rs2;
  assign fwd_data = wr_data_q;
`else
  assign byp_rs1 = 1'b0;
  assign byp_rs2 = 1'b0;
`endif

  // Destination matches always stall; sources may be covered by the bypass.
  assign haz_rs1     = pending_q[issue_rs1] && !byp_rs1;
  assign haz_rs2     = pending_q[issue_rs2] && !byp_rs2;
  assign haz_rd      = pending_q[issue_rd];
  assign issue_stall = !rst && issue_valid && (haz_rs1 || haz_rs2 || haz_rd);
  assign issue_acc   = !rst && issue_valid && !issue_stall && (issue_rd != '0);

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (issue_acc) begin
      set_vec[issue_rd] = 1'b1;
    end
    if (reg_write) begin
      clr_vec[wr_rd_q] = 1'b1;
    end
    // Set is applied after clear so a same-index collision leaves the bit pending.
    pending_d    = (pending_q & ~clr_vec) | set_vec;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench for reg_wb_arbiter: reset, arbitration, hazards, x0, WAW and mid-operation reset.
// Build with or without WB_BYPASS_EN to match the RTL.
module tb_reg_wb_arbiter;
  import rv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid, issue_valid;
  reg_idx_t    a_rd, b_rd, issue_rd, issue_rs1, issue_rs2;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready, issue_stall, reg_write;
  reg_idx_t    wr_rd;
  logic [31:0] wr_data;
`ifdef WB_BYPASS_EN
  logic        fwd_rs1, fwd_rs2;
  logic [31:0] fwd_data;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  reg_wb_arbiter #(.XLEN(32), .NREG(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .a_valid     (a_valid),
    .a_rd        (a_rd),
    .a_data      (a_data),
    .a_ready     (a_ready),
    .b_valid     (b_valid),
    .b_rd        (b_rd),
    .b_data      (b_data),
    .b_ready     (b_ready),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_rs1   (issue_rs1),
    .issue_rs2   (issue_rs2),
    .issue_stall (issue_stall),
    .reg_write   (reg_write),
    .wr_rd       (wr_rd),
    .wr_data     (wr_data)
`ifdef WB_BYPASS_EN
    ,
    .fwd_rs1     (fwd_rs1),
    .fwd_rs2     (fwd_rs2),
    .fwd_data    (fwd_data)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    a_valid = 0; a_rd = '0; a_data = '0;
    b_valid = 0; b_rd = '0; b_data = '0;
    issue_valid = 0; issue_rd = '0; issue_rs1 = '0; issue_rs2 = '0;
  endtask

  task automatic issue(input reg_idx_t rd, input reg_idx_t rs1, input reg_idx_t rs2);
    issue_valid = 1; issue_rd = rd; issue_rs1 = rs1; issue_rs2 = rs2;
  endtask

  // Advance one cycle; inputs are driven 1ns after the edge, checks 2ns later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    idle();
    // Reset held two cycles with every input active
    rst = 1;
    a_valid = 1; a_rd = 5'd3; a_data = 32'h11;
    b_valid = 1; b_rd = 5'd4; b_data = 32'h22;
    issue(5'd5, 5'd5, 5'd5);
    settle();
    chk("rst_a_ready0", a_ready, 0);
    chk("rst_b_ready0", b_ready, 0);
    chk("rst_stall0", issue_stall, 0);
    chk("rst_regwr0", reg_write, 0);
    cyc();
    settle();
    chk("rst_a_ready1", a_ready, 0);
    chk("rst_b_ready1", b_ready, 0);
    chk("rst_stall1", issue_stall, 0);
    chk("rst_regwr1", reg_write, 0);
    chk("rst_wr_rd", wr_rd, 0);
    chk("rst_wr_data", wr_data, 0);
    cyc();

    // Release reset; issue rd=5 then confirm pending[5]
    rst = 0;
    idle();
    issue(5'd5, 5'd1, 5'd2);
    settle();
    chk("issue5_nostall", issue_stall, 0);
    cyc();
    issue(5'd0, 5'd5, 5'd0);
    settle();
    chk("pend5_stall", issue_stall, 1);
    chk("idle_regwr", reg_write, 0);
    cyc();

    // Contention: A first after reset, then B
    idle();
    a_valid = 1; a_rd = 5'd3; a_data = 32'h11;
    b_valid = 1; b_rd = 5'd4; b_data = 32'h22;
    settle();
    chk("cont1_a_ready", a_ready, 1);
    chk("cont1_b_ready", b_ready, 0);
    cyc();
    settle();
    chk("cont2_a_ready", a_ready, 0);
    chk("cont2_b_ready", b_ready, 1);
    chk("cont2_regwr", reg_write, 1);
    chk("cont2_wr_rd", wr_rd, 3);
    chk("cont2_wr_data", wr_data, 32'h11);
    cyc();
    idle();
    settle();
    chk("none_a_ready", a_ready, 0);
    chk("none_b_ready", b_ready, 0);
    chk("cont3_regwr", reg_write, 1);
    chk("cont3_wr_rd", wr_rd, 4);
    chk("cont3_wr_data", wr_data, 32'h22);
    cyc();

    // Only B valid: granted, pointer unchanged; hold of wr_rd/wr_data
    b_valid = 1; b_rd = 5'd6; b_data = 32'h33;
    settle();
    chk("hold_regwr", reg_write, 0);
    chk("hold_wr_rd", wr_rd, 4);
    chk("hold_wr_data", wr_data, 32'h22);
    chk("onlyb_b_ready", b_ready, 1);
    chk("onlyb_a_ready", a_ready, 0);
    cyc();
    // Both valid again with pointer still at A; A carries rd=0
    idle();
    a_valid = 1; a_rd = 5'd0; a_data = 32'hBEEF;
    b_valid = 1; b_rd = 5'd0; b_data = 32'h1;
    settle();
    chk("ptr_keep_a_ready", a_ready, 1);
    chk("b6_regwr", reg_write, 1);
    chk("b6_wr_rd", wr_rd, 6);
    chk("b6_wr_data", wr_data, 32'h33);
    cyc();
    idle();
    settle();
    chk("rd0_a_noregwr", reg_write, 0);
    cyc();

    // RAW hazard on rd=7, written by B
    issue(5'd7, 5'd0, 5'd0);
    settle();
    chk("issue7_nostall", issue_stall, 0);
    cyc();
    issue(5'd0, 5'd7, 5'd0);
    b_valid = 1; b_rd = 5'd7; b_data = 32'h77;
    settle();
    chk("raw7_stall", issue_stall, 1);
    chk("raw7_b_ready", b_ready, 1);
    cyc();
    b_valid = 0;
    settle();
    chk("raw7_regwr", reg_write, 1);
    chk("raw7_wr_rd", wr_rd, 7);
`ifdef WB_BYPASS_EN
    chk("raw7_wrcyc_stall", issue_stall, 0);
    chk("raw7_fwd_rs1", fwd_rs1, 1);
    chk("raw7_fwd_rs2", fwd_rs2, 0);
    chk("raw7_fwd_data", fwd_data, 32'h77);
`else
    chk("raw7_wrcyc_stall", issue_stall, 1);
`endif
    cyc();
    settle();
    chk("raw7_after_stall", issue_stall, 0);
    cyc();

    // x0 write by B and rs1=0 issue
    idle();
    b_valid = 1; b_rd = 5'd0; b_data = 32'hDEAD;
    issue(5'd0, 5'd0, 5'd0);
    settle();
    chk("x0_b_ready", b_ready, 1);
    chk("x0_rs_nostall", issue_stall, 0);
    cyc();
    idle();
    issue(5'd0, 5'd0, 5'd5);
    settle();
    chk("x0_noregwr", reg_write, 0);
    chk("pend5_kept_stall", issue_stall, 1);
    cyc();

    // WAW on rd=9
    idle();
    issue(5'd9, 5'd0, 5'd0);
    settle();
    chk("issue9_nostall", issue_stall, 0);
    cyc();
    a_valid = 1; a_rd = 5'd9; a_data = 32'h99;
    settle();
    chk("waw9_stall", issue_stall, 1);
    chk("waw9_a_ready", a_ready, 1);
    cyc();
    a_valid = 0;
    settle();
    chk("waw9_regwr", reg_write, 1);
    chk("waw9_wr_rd", wr_rd, 9);
    chk("waw9_wrcyc_stall", issue_stall, 1);
    cyc();
    settle();
    chk("waw9_accept", issue_stall, 0);
    cyc();
    issue(5'd0, 5'd9, 5'd0);
    settle();
    chk("waw9_repend", issue_stall, 1);
    cyc();

    // Set and clear of rd=10 on the same edge: set wins
    idle();
    a_valid = 1; a_rd = 5'd10; a_data = 32'hAA;
    settle();
    chk("sw10_a_ready", a_ready, 1);
    cyc();
    a_valid = 0;
    issue(5'd10, 5'd0, 5'd0);
    settle();
    chk("sw10_regwr", reg_write, 1);
    chk("sw10_issue_nostall", issue_stall, 0);
    cyc();
    issue(5'd0, 5'd10, 5'd0);
    settle();
    chk("sw10_set_wins", issue_stall, 1);
    cyc();

    // Pointer now at B after the earlier rd=0 contest
    idle();
    a_valid = 1; a_rd = 5'd11; a_data = 32'hB1;
    b_valid = 1; b_rd = 5'd12; b_data = 32'hB2;
    settle();
    chk("rr_b_ready", b_ready, 1);
    chk("rr_a_ready", a_ready, 0);
    cyc();
    idle();
    settle();
    chk("rr_wr_rd", wr_rd, 12);
    chk("rr_wr_data", wr_data, 32'hB2);
    cyc();

    // Mid-operation reset: contested grant to A, then reset while it is in flight
    a_valid = 1; a_rd = 5'd13; a_data = 32'h13;
    b_valid = 1; b_rd = 5'd14; b_data = 32'h14;
    settle();
    chk("mid_a_ready", a_ready, 1);
    cyc();
    idle();
    rst = 1;
    settle();
    chk("mid_rst_regwr", reg_write, 0);
    cyc();
    rst = 0;
    issue(5'd10, 5'd5, 5'd9);
    settle();
    chk("mid_post_regwr", reg_write, 0);
    chk("mid_pend_cleared", issue_stall, 0);
    cyc();
    idle();
    a_valid = 1; a_rd = 5'd15; a_data = 32'h15;
    b_valid = 1; b_rd = 5'd16; b_data = 32'h16;
    settle();
    chk("mid_ptr_reset_a", a_ready, 1);
    cyc();
    idle();
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
